// File: rtl/bcd_converter_seq.sv
// -----------------------------------------------------------------------------
// bcd_converter_seq
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// It performs one shift per clock, so a conversion takes BIN_WIDTH cycles.
// It sits between the score accumulator and the seven-segment display driver.
//
// Parameters:
//   BIN_WIDTH  width of the binary input (4..32)
//   DIGITS     number of BCD digits produced (1..10)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   bin_in holds a value to convert
//   in_ready   converter can accept a value (high only while idle)
//   bin_in     unsigned binary value, sampled only on the accepting edge
//   out_valid  result registers hold a completed conversion
//   out_ready  consumer accepts the result
//   bcd_out    BCD digits; [3:0] is ones, [7:4] is tens, and so on
//   blank      bit k high = digit k is a leading zero (bit 0 is always 0)
//   overflow   value >= 10^DIGITS; bcd_out then holds value mod 10^DIGITS
// -----------------------------------------------------------------------------
module bcd_converter_seq #(
  parameter int BIN_WIDTH = 10,
  parameter int DIGITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [BIN_WIDTH-1:0]  bin_q, bin_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sticky_q, sticky_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [BW-1:0]         bcd_out_q, bcd_out_d;
  logic [DIGITS-1:0]     blank_q, blank_d;
  logic                  overflow_q, overflow_d;

  // Datapath for one iteration: per-digit adjust, then a one-bit shift.
  logic [BW-1:0]         adj;
  logic [BW-1:0]         bcd_shifted;
  logic [BIN_WIDTH-1:0]  bin_shifted;
  logic                  shift_out;
  logic [DIGITS-1:0]     blank_new;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      // Digits never exceed 12 after adjust, so the 4-bit add cannot wrap.
      assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                         : bcd_q[4*gi +: 4];
      // Digit k is blanked when it and every more-significant digit are zero;
      // the ones digit is always shown so a zero value still displays "0".
      if (gi == 0) begin : g_ones
        assign blank_new[gi] = 1'b0;
      end else begin : g_upper
        assign blank_new[gi] = ~|bcd_shifted[BW-1:4*gi];
      end
    end
  endgenerate

  // A bit leaving the top digit means the true value carried past 10^DIGITS;
  // the remaining field is then exactly value mod 10^DIGITS.
  assign shift_out   = adj[BW-1];
  assign bcd_shifted = {adj[BW-2:0], bin_q[BIN_WIDTH-1]};
  assign bin_shifted = {bin_q[BIN_WIDTH-2:0], 1'b0};

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    bcd_out_d   = bcd_out_q;
    blank_d     = blank_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bin_d      = bin_in;
          bcd_d      = '0;
          sticky_d   = 1'b0;
          cnt_d      = CW'(BIN_WIDTH);
          state_d    = S_SHIFT;
          in_ready_d = 1'b0;
        end
      end

      S_SHIFT: begin
        bcd_d    = bcd_shifted;
        bin_d    = bin_shifted;
        sticky_d = sticky_q | shift_out;
        cnt_d    = cnt_q - CW'(1);
        // Last iteration: capture the finished result straight into the
        // output registers so they are valid on the same edge as out_valid.
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          bcd_out_d   = bcd_shifted;
          blank_d     = blank_new;
          overflow_d  = sticky_q | shift_out;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bcd_out_q   <= '0;
      blank_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bcd_out_q   <= bcd_out_d;
      blank_q     <= blank_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_out_q;
  assign blank     = blank_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_converter_seq
//
// Drives a 3-digit and a 4-digit converter (both 10-bit input) in lockstep.
// A behavioural model tracks the handshake/latency rule and the last accepted
// value; the expected digits, blank mask and overflow come from plain decimal
// arithmetic. Directed cases add literal expectations.
// -----------------------------------------------------------------------------
module tb_bcd_converter_seq;

  localparam int BW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  bin_in = '0;

  logic        in_ready3, out_valid3, overflow3;
  logic [11:0] bcd_out3;
  logic [2:0]  blank3;
  logic        in_ready4, out_valid4, overflow4;
  logic [15:0] bcd_out4;
  logic [3:0]  blank4;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  bcd_converter_seq #(.BIN_WIDTH(BW), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .bin_in(bin_in), .out_valid(out_valid3), .out_ready(out_ready),
    .bcd_out(bcd_out3), .blank(blank3), .overflow(overflow3)
  );

  bcd_converter_seq #(.BIN_WIDTH(BW), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .bin_in(bin_in), .out_valid(out_valid4), .out_ready(out_ready),
    .bcd_out(bcd_out4), .blank(blank4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic longint pow10(input int k);
    longint p = 1;
    repeat (k) p = p * 10;
    return p;
  endfunction

  function automatic longint bcd_of(input longint v, input int d);
    longint m = v % pow10(d);
    longint r = 0;
    for (int i = 0; i < d; i++) begin
      r = r | ((m % 10) << (4 * i));
      m = m / 10;
    end
    return r;
  endfunction

  function automatic longint blank_of(input longint v, input int d);
    longint m = v % pow10(d);
    longint r = 0;
    for (int k = 1; k < d; k++)
      if (m < pow10(k)) r = r | (longint'(1) << k);
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  // 0 = idle, 1 = converting (m_cnt cycles left), 2 = result presented
  int     m_state = 0;
  int     m_cnt = 0;
  longint m_val = 0;
  longint m_res = 0;
  bit     m_has = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_has   <= 1'b0;
      m_res   <= 0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
             m_val   <= longint'(bin_in);
             m_cnt   <= BW;
             m_state <= 1;
           end
        1: begin
             m_cnt <= m_cnt - 1;
             if (m_cnt == 1) begin
               m_state <= 2;
               m_res   <= m_val;
               m_has   <= 1'b1;
             end
           end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready3",  in_ready3,  m_state == 0);
      chk("out_valid3", out_valid3, m_state == 2);
      chk("bcd_out3",   bcd_out3,   m_has ? bcd_of(m_res, 3) : 0);
      chk("blank3",     blank3,     m_has ? blank_of(m_res, 3) : 0);
      chk("overflow3",  overflow3,  m_has ? (m_res >= 1000) : 0);
      chk("in_ready4",  in_ready4,  m_state == 0);
      chk("out_valid4", out_valid4, m_state == 2);
      chk("bcd_out4",   bcd_out4,   m_has ? bcd_of(m_res, 4) : 0);
      chk("blank4",     blank4,     m_has ? blank_of(m_res, 4) : 0);
      chk("overflow4",  overflow4,  m_has ? (m_res >= 10000) : 0);
    end
  end

  // ---------------- driver helpers ----------------
  // Raise in_valid and wait for the accepting edge; returns just after it.
  task automatic do_accept(input int v);
    bit ok = 1'b0;
    bin_in   = 10'(v);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready3) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Count edges from just after acceptance until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid3 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid3) chk("result_timeout", 0, 1);
  endtask

  task automatic convert(input int v, input int pre_gap, input int ready_gap,
                         output int lat);
    repeat (pre_gap) begin @(posedge clk); #1; end
    do_accept(v);
    in_valid = 1'b0;
    chk("in_ready_falls", in_ready3, 1'b0);
    wait_result(lat);
    $display("[TB] conv %0d: lat=%0d bcd3=%03h blank3=%b ovf3=%0b bcd4=%04h blank4=%b ovf4=%0b",
             v, lat, bcd_out3, blank3, overflow3, bcd_out4, blank4, overflow4);
    repeat (ready_gap) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_returns", in_ready3, 1'b1);
  endtask

  task automatic directed(input int v, input logic [11:0] e_bcd,
                          input logic [2:0] e_blank, input logic e_ovf);
    int lat;
    repeat (1) begin @(posedge clk); #1; end
    do_accept(v);
    in_valid = 1'b0;
    wait_result(lat);
    $display("[TB] directed %0d: lat=%0d bcd=%03h blank=%b ovf=%0b",
             v, lat, bcd_out3, blank3, overflow3);
    chk("lit_latency", lat, BW);
    chk("lit_bcd",     bcd_out3, e_bcd);
    chk("lit_blank",   blank3, e_blank);
    chk("lit_ovf",     overflow3, e_ovf);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("lit_in_ready_back", in_ready3, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    #12;
    chk("rst_in_ready",  in_ready3, 1'b1);
    chk("rst_out_valid", out_valid3, 1'b0);
    chk("rst_bcd",       bcd_out3, 12'h000);
    chk("rst_blank",     blank3, 3'b000);
    chk("rst_ovf",       overflow3, 1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    directed(999,  12'h999, 3'b000, 1'b0);
    directed(0,    12'h000, 3'b110, 1'b0);
    directed(7,    12'h007, 3'b110, 1'b0);
    directed(40,   12'h040, 3'b100, 1'b0);
    directed(1023, 12'h023, 3'b100, 1'b1);
    // The 4-digit instance still holds the 1023 result.
    chk("lit_bcd4_1023",   bcd_out4, 16'h1023);
    chk("lit_blank4_1023", blank4, 4'b0000);
    chk("lit_ovf4_1023",   overflow4, 1'b0);

    // Backpressure with a second request waiting on in_valid.
    @(posedge clk); #1;
    do_accept(123);
    bin_in = 10'd456;
    wait_result(lat);
    chk("bp_latency", lat, BW);
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold_bcd", bcd_out3, 12'h123);
      chk("bp_in_ready", in_ready3, 1'b0);
      chk("bp_valid",    out_valid3, 1'b1);
      @(posedge clk); #1;
    end
    chk("bp_hold_bcd_end", bcd_out3, 12'h123);
    $display("[TB] backpressure 123 held for 6 cycles");
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", in_ready3, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted_456", in_ready3, 1'b0);
    wait_result(lat);
    $display("[TB] conv 456 after backpressure: lat=%0d bcd=%03h", lat, bcd_out3);
    chk("bp_456_latency", lat, BW);
    chk("bp_456_bcd", bcd_out3, 12'h456);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset mid-conversion of 500.
    @(posedge clk); #1;
    do_accept(500);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  in_ready3, 1'b1);
    chk("arst_out_valid", out_valid3, 1'b0);
    chk("arst_bcd",       bcd_out3, 12'h000);
    chk("arst_blank",     blank3, 3'b000);
    chk("arst_ovf",       overflow3, 1'b0);
    $display("[TB] reset asserted during conversion of 500");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("arst_no_valid", out_valid3, 1'b0);
      @(posedge clk); #1;
    end
    directed(37, 12'h037, 3'b100, 1'b0);

    // Full sweep with random gaps; the per-cycle compare checks everything.
    for (int v = 0; v < 1024; v++) begin
      convert(v, $urandom_range(0, 3), $urandom_range(0, 3), lat);
      chk("sweep_latency", lat, BW);
    end

    repeat (3) begin @(posedge clk); #1; end
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
